line_scanout: RTL and testbench

- Read-side controller for the ping-pong RGB line buffers.
- Produces raster timing with counters: hsync, vsync and data-enable.
- Issues read-enable and address to the buffer for the current line and presents the returned RGB pixels aligned to data-enable.
- Exchanges line-full/line-release handshakes with the buffer writer, so each buffer is refilled only after it has been scanned out.

---
 rtl/line_scanout.sv | 241 ++++++++++++++++++++++++
 tb/tb_line_scanout.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scanout.sv
// line_scanout: read-side raster controller for the ping-pong RGB line buffers.
// Generates hsync/vsync/de, reads each active line from its buffer and releases it for refill.
module line_scanout #(
    parameter int H_ACTIVE = 100,
    parameter int H_FP     = 4,
    parameter int H_SYNC   = 12,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 75,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 3,
    parameter int AW       = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          full1,
    input  logic          full2,
    input  logic [7:0]    red_pix1,
    input  logic [7:0]    green_pix1,
    input  logic [7:0]    blue_pix1,
    input  logic [7:0]    red_pix2,
    input  logic [7:0]    green_pix2,
    input  logic [7:0]    blue_pix2,
    output logic          RE1,
    output logic          RE2,
    output logic [AW-1:0] Addr1,
    output logic [AW-1:0] Addr2,
    output logic          release1,
    output logic          release2,
    output logic [7:0]    pix_r,
    output logic [7:0]    pix_g,
    output logic [7:0]    pix_b,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          underrun
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT_C      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_RD_LAST_C  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] H_SYNC_BEG_C = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST_C     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG_C = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST_C     = VW'(V_TOTAL - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_r;
    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic          sel_r;
    logic          line_ok_r;
    logic          underrun_r;
    logic [AW-1:0] addr1_hold_r;
    logic [AW-1:0] addr2_hold_r;
    logic          release1_r;
    logic          release2_r;
    logic          act_d1_r;
    logic          hs_n_d1_r;
    logic          vs_n_d1_r;
    logic          rd_d1_r;
    logic          rd_sel_d1_r;
    logic          de_r;
    logic          hsync_r;
    logic          vsync_r;
    logic [23:0]   pix_r_r;

    logic          run_s;
    logic          act_s;
    logic          hs_s;
    logic          vs_s;
    logic          line_start_s;
    logic          line_done_s;
    logic          frame_end_s;
    logic          full_sel_s;
    logic          rd_ok_s;
    logic          rd_s;
    logic [AW-1:0] rd_addr_s;

    // Raw raster timing and read qualification decoded from the counters
    always_comb begin
        run_s        = (state_r == ST_RUN);
        act_s        = run_s && (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
        hs_s         = run_s && (h_cnt_r >= H_SYNC_BEG_C) && (h_cnt_r < H_SYNC_END_C);
        vs_s         = run_s && (v_cnt_r >= V_SYNC_BEG_C) && (v_cnt_r < V_SYNC_END_C);
        line_start_s = act_s && (h_cnt_r == {HW{1'b0}});
        line_done_s  = act_s && (h_cnt_r == H_RD_LAST_C);
        frame_end_s  = run_s && (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);
        full_sel_s   = sel_r ? full2 : full1;
        // The line-start cycle must already read, so it uses the live full flag
        if (line_start_s) begin
            rd_ok_s = full_sel_s;
        end else begin
            rd_ok_s = line_ok_r;
        end
        rd_s      = act_s && rd_ok_s;
        rd_addr_s = AW'(h_cnt_r);
    end

    // Read enable and address steering towards the buffer of the current line
    always_comb begin
        RE1   = 1'b0;
        RE2   = 1'b0;
        Addr1 = addr1_hold_r;
        Addr2 = addr2_hold_r;
        if (rd_s && sel_r) begin
            RE2   = 1'b1;
            Addr2 = rd_addr_s;
        end else if (rd_s) begin
            RE1   = 1'b1;
            Addr1 = rd_addr_s;
        end else begin
            RE1 = 1'b0;
            RE2 = 1'b0;
        end
    end

    // Run/idle FSM with the raster counters and the line-buffer select
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
            sel_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    h_cnt_r <= {HW{1'b0}};
                    v_cnt_r <= {VW{1'b0}};
                    sel_r   <= 1'b0;
                    state_r <= enable ? ST_RUN : ST_IDLE;
                end
                ST_RUN: begin
                    if (h_cnt_r == H_LAST_C) begin
                        h_cnt_r <= {HW{1'b0}};
                        if (v_cnt_r == V_LAST_C) begin
                            v_cnt_r <= {VW{1'b0}};
                            sel_r   <= 1'b0;
                            state_r <= enable ? ST_RUN : ST_IDLE;
                        end else begin
                            v_cnt_r <= v_cnt_r + VW'(1);
                        end
                    end else begin
                        h_cnt_r <= h_cnt_r + HW'(1);
                        if (line_done_s) begin
                            sel_r <= ~sel_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-line latch of buffer readiness, sticky underrun, address hold and release pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            line_ok_r    <= 1'b0;
            underrun_r   <= 1'b0;
            addr1_hold_r <= {AW{1'b0}};
            addr2_hold_r <= {AW{1'b0}};
            release1_r   <= 1'b0;
            release2_r   <= 1'b0;
        end else begin
            if (line_start_s) begin
                line_ok_r <= full_sel_s;
                if (!full_sel_s) begin
                    underrun_r <= 1'b1;
                end
            end
            if (frame_end_s && !enable) begin
                addr1_hold_r <= {AW{1'b0}};
                addr2_hold_r <= {AW{1'b0}};
            end else begin
                if (RE1) begin
                    addr1_hold_r <= rd_addr_s;
                end
                if (RE2) begin
                    addr2_hold_r <= rd_addr_s;
                end
            end
            release1_r <= line_done_s && rd_ok_s && !sel_r;
            release2_r <= line_done_s && rd_ok_s && sel_r;
        end
    end

    // Two-stage output pipeline matching the one-clock buffer read latency
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            act_d1_r    <= 1'b0;
            hs_n_d1_r   <= 1'b1;
            vs_n_d1_r   <= 1'b1;
            rd_d1_r     <= 1'b0;
            rd_sel_d1_r <= 1'b0;
            de_r        <= 1'b0;
            hsync_r     <= 1'b1;
            vsync_r     <= 1'b1;
            pix_r_r     <= 24'h000000;
        end else begin
            act_d1_r    <= act_s;
            hs_n_d1_r   <= ~hs_s;
            vs_n_d1_r   <= ~vs_s;
            rd_d1_r     <= rd_s;
            rd_sel_d1_r <= sel_r;
            de_r        <= act_d1_r;
            hsync_r     <= hs_n_d1_r;
            vsync_r     <= vs_n_d1_r;
            if (rd_d1_r && rd_sel_d1_r) begin
                pix_r_r <= {red_pix2, green_pix2, blue_pix2};
            end else if (rd_d1_r) begin
                pix_r_r <= {red_pix1, green_pix1, blue_pix1};
            end else begin
                pix_r_r <= 24'h000000;
            end
        end
    end

    assign release1 = release1_r;
    assign release2 = release2_r;
    assign pix_r    = pix_r_r[23:16];
    assign pix_g    = pix_r_r[15:8];
    assign pix_b    = pix_r_r[7:0];
    assign de       = de_r;
    assign hsync    = hsync_r;
    assign vsync    = vsync_r;
    assign underrun = underrun_r;

endmodule

// File: tb/tb_line_scanout.sv
// Self-checking bench for line_scanout: a small raster/buffer model predicts every output per clock.
module tb_line_scanout;
    localparam int H_ACTIVE = 4;
    localparam int H_FP     = 1;
    localparam int H_SYNC   = 2;
    localparam int H_BP     = 1;
    localparam int V_ACTIVE = 2;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 1;
    localparam int V_BP     = 1;
    localparam int AW       = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          full1 = 1'b0;
    logic          full2 = 1'b0;
    logic [7:0]    red_pix1, green_pix1, blue_pix1;
    logic [7:0]    red_pix2, green_pix2, blue_pix2;
    logic          RE1, RE2;
    logic [AW-1:0] Addr1, Addr2;
    logic          release1, release2;
    logic [7:0]    pix_r, pix_g, pix_b;
    logic          de, hsync, vsync, underrun;

    int n_checks = 0;
    int n_fail = 0;

    // Buffer contents and registered read ports (garbage when not read)
    logic [23:0] buf1 [H_ACTIVE];
    logic [23:0] buf2 [H_ACTIVE];
    logic [23:0] rd1_q = 24'h0;
    logic [23:0] rd2_q = 24'h0;
    assign {red_pix1, green_pix1, blue_pix1} = rd1_q;
    assign {red_pix2, green_pix2, blue_pix2} = rd2_q;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rd1_q <= RE1 ? buf1[Addr1] : 24'($urandom);
        rd2_q <= RE2 ? buf2[Addr2] : 24'($urandom);
    end

    line_scanout #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .AW(AW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .full1(full1), .full2(full2),
        .red_pix1(red_pix1), .green_pix1(green_pix1), .blue_pix1(blue_pix1),
        .red_pix2(red_pix2), .green_pix2(green_pix2), .blue_pix2(blue_pix2),
        .RE1(RE1), .RE2(RE2), .Addr1(Addr1), .Addr2(Addr2),
        .release1(release1), .release2(release2),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .de(de), .hsync(hsync), .vsync(vsync), .underrun(underrun)
    );

    // Reference model: frame position, per-line readiness, 2-deep output history
    bit          m_run;
    int          m_p;
    bit          m_und;
    bit          m_rel1, m_rel2;
    bit          m_line_ok [V_ACTIVE];
    logic [AW-1:0] m_a1, m_a2;
    bit          hd_de [2];
    bit          hd_hs [2];
    bit          hd_vs [2];
    logic [23:0] hd_pix [2];
    int          r_h, r_v;
    bit          r_act, r_hs, r_vs, r_buf2, r_rd;
    logic [23:0] r_pix;

    task automatic model_reset();
        m_run = 1'b0; m_p = 0; m_und = 1'b0; m_rel1 = 1'b0; m_rel2 = 1'b0;
        m_a1 = '0; m_a2 = '0;
        for (int i = 0; i < 2; i++) begin
            hd_de[i] = 1'b0; hd_hs[i] = 1'b0; hd_vs[i] = 1'b0; hd_pix[i] = 24'h0;
        end
    endtask

    task automatic model_eval();
        r_h    = m_p % H_TOTAL;
        r_v    = m_p / H_TOTAL;
        r_act  = m_run && (r_h < H_ACTIVE) && (r_v < V_ACTIVE);
        r_hs   = m_run && (r_h >= H_ACTIVE + H_FP) && (r_h < H_ACTIVE + H_FP + H_SYNC);
        r_vs   = m_run && (r_v >= V_ACTIVE + V_FP) && (r_v < V_ACTIVE + V_FP + V_SYNC);
        r_buf2 = (r_v % 2) == 1;
        r_rd   = 1'b0;
        if (r_act) begin
            if (r_h == 0) m_line_ok[r_v] = r_buf2 ? full2 : full1;
            r_rd = m_line_ok[r_v];
        end
        r_pix = r_rd ? (r_buf2 ? buf2[r_h] : buf1[r_h]) : 24'h0;
    endtask

    task automatic model_commit();
        bit ok;
        ok = r_act ? m_line_ok[r_v] : 1'b0;
        m_rel1 = r_act && (r_h == H_ACTIVE - 1) && ok && !r_buf2;
        m_rel2 = r_act && (r_h == H_ACTIVE - 1) && ok && r_buf2;
        if (r_act && r_h == 0 && !ok) m_und = 1'b1;
        if (r_rd && !r_buf2) m_a1 = AW'(r_h);
        if (r_rd && r_buf2) m_a2 = AW'(r_h);
        hd_de[1] = hd_de[0];   hd_de[0] = r_act;
        hd_hs[1] = hd_hs[0];   hd_hs[0] = r_hs;
        hd_vs[1] = hd_vs[0];   hd_vs[0] = r_vs;
        hd_pix[1] = hd_pix[0]; hd_pix[0] = r_pix;
        if (!m_run) begin
            if (enable) begin m_run = 1'b1; m_p = 0; end
        end else if (m_p == FRAME - 1) begin
            m_run = enable; m_p = 0;
            if (!enable) begin m_a1 = '0; m_a2 = '0; end
        end else begin
            m_p = m_p + 1;
        end
    endtask

    // Scenario driver: full_mode 0 both full, 1 random per clock, 2 buffer 2 never full
    task automatic test_scan(input string tag, input int ncyc, input bit en,
                             input int full_mode, input int drop_at);
        logic          e_re1, e_re2;
        logic [AW-1:0] e_a1, e_a2;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            if (c == 0) enable = en;
            if (c == drop_at) enable = 1'b0;
            case (full_mode)
                1: begin full1 = 1'($urandom); full2 = 1'($urandom); end
                2: begin full1 = 1'b1; full2 = 1'b0; end
                default: begin full1 = 1'b1; full2 = 1'b1; end
            endcase
            model_eval();
            e_re1 = r_rd && !r_buf2;
            e_re2 = r_rd && r_buf2;
            e_a1  = e_re1 ? AW'(r_h) : m_a1;
            e_a2  = e_re2 ? AW'(r_h) : m_a2;
            #1;
            n_checks++;
            if (RE1 !== e_re1) begin n_fail++; $display("FAIL %s re1 c=%0d got %b exp %b", tag, c, RE1, e_re1); end
            n_checks++;
            if (RE2 !== e_re2) begin n_fail++; $display("FAIL %s re2 c=%0d got %b exp %b", tag, c, RE2, e_re2); end
            n_checks++;
            if (Addr1 !== e_a1) begin n_fail++; $display("FAIL %s addr1 c=%0d got %0d exp %0d", tag, c, Addr1, e_a1); end
            n_checks++;
            if (Addr2 !== e_a2) begin n_fail++; $display("FAIL %s addr2 c=%0d got %0d exp %0d", tag, c, Addr2, e_a2); end
            n_checks++;
            if (de !== hd_de[1]) begin n_fail++; $display("FAIL %s de c=%0d got %b exp %b", tag, c, de, hd_de[1]); end
            n_checks++;
            if (hsync !== !hd_hs[1]) begin n_fail++; $display("FAIL %s hsync c=%0d got %b exp %b", tag, c, hsync, !hd_hs[1]); end
            n_checks++;
            if (vsync !== !hd_vs[1]) begin n_fail++; $display("FAIL %s vsync c=%0d got %b exp %b", tag, c, vsync, !hd_vs[1]); end
            n_checks++;
            if ({pix_r, pix_g, pix_b} !== hd_pix[1]) begin
                n_fail++; $display("FAIL %s pix c=%0d got %h exp %h", tag, c, {pix_r, pix_g, pix_b}, hd_pix[1]);
            end
            n_checks++;
            if (release1 !== m_rel1) begin n_fail++; $display("FAIL %s release1 c=%0d got %b exp %b", tag, c, release1, m_rel1); end
            n_checks++;
            if (release2 !== m_rel2) begin n_fail++; $display("FAIL %s release2 c=%0d got %b exp %b", tag, c, release2, m_rel2); end
            n_checks++;
            if (underrun !== m_und) begin n_fail++; $display("FAIL %s underrun c=%0d got %b exp %b", tag, c, underrun, m_und); end
            model_commit();
        end
    endtask

    task automatic test_reset();
        enable = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if ({RE1, RE2, release1, release2, de, underrun} !== 6'b0) begin
            n_fail++; $display("FAIL reset ctl got %b exp 000000", {RE1, RE2, release1, release2, de, underrun});
        end
        n_checks++;
        if ({hsync, vsync} !== 2'b11) begin n_fail++; $display("FAIL reset sync got %b exp 11", {hsync, vsync}); end
        n_checks++;
        if ({Addr1, Addr2} !== '0) begin n_fail++; $display("FAIL reset addr got %h exp 0", {Addr1, Addr2}); end
        n_checks++;
        if ({pix_r, pix_g, pix_b} !== 24'h0) begin n_fail++; $display("FAIL reset pix got %h exp 0", {pix_r, pix_g, pix_b}); end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        test_scan("idle", 4, 1'b0, 0, -1);
    endtask

    task automatic test_stream();
        buf1[0] = 24'h112233; buf1[1] = 24'h445566; buf1[2] = 24'h778899; buf1[3] = 24'hAABBCC;
        buf2[0] = 24'h010203; buf2[1] = 24'h040506; buf2[2] = 24'h070809; buf2[3] = 24'h0A0B0C;
        test_scan("stream", 2 * FRAME + 3, 1'b1, 0, -1);
    endtask

    task automatic test_underrun();
        test_scan("underrun", FRAME + 10, 1'b1, 2, -1);
        test_scan("randfull", 3 * FRAME, 1'b1, 1, -1);
    endtask

    task automatic test_enable_drop();
        test_scan("endrop", FRAME + 30, 1'b1, 0, int'($urandom_range(5, 30)));
        n_checks++;
        if (m_run || {de, RE1, RE2, hsync, vsync} !== 5'b00011) begin
            n_fail++; $display("FAIL endrop idle run=%b got de/re1/re2/hs/vs %b exp 00011", m_run, {de, RE1, RE2, hsync, vsync});
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < H_ACTIVE; i++) begin
            buf1[i] = 24'($urandom);
            buf2[i] = 24'($urandom);
        end
        test_scan("b2b", 2 * FRAME + 5, 1'b1, 1, -1);
    endtask

    task automatic test_reset_midline();
        bit found = 1'b0;
        for (int c = 0; c < 2 * FRAME && !found; c++) begin
            @(negedge clock);
            full1 = 1'b1; full2 = 1'b1;
            model_eval();
            if (r_act && r_h == 2) found = 1'b1;
            else model_commit();
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL midrst search got none exp active h=2"); end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({RE1, RE2, release1, release2, de, underrun, hsync, vsync, pix_r, pix_g, pix_b, Addr1, Addr2} !==
            {8'b00000011, 24'h0, {(2 * AW){1'b0}}}) begin
            n_fail++; $display("FAIL midrst async got re=%b%b rel=%b%b de=%b und=%b hv=%b%b exp all reset",
                               RE1, RE2, release1, release2, de, underrun, hsync, vsync);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if ({release1, release2} !== 2'b00) begin n_fail++; $display("FAIL midrst release got %b exp 00", {release1, release2}); end
        end
        enable = 1'b0;
        model_reset();
        reset_n = 1'b1;
        test_scan("restart", FRAME + 6, 1'b1, 0, -1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_underrun();
        test_enable_drop();
        test_back_to_back();
        test_reset_midline();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
